// File: rtl/alu_op_sequencer.sv
// Sequences ALU datapath strobes: LOAD_Y -> EXEC x HOLD_CYCLES -> CAPT -> WB_LO [-> WB_HI] -> DONE.
// Latency from accepting edge to done: 4+HOLD_CYCLES (ops 2..11), 5+HOLD_CYCLES (ops 0/1), 1 (illegal op).
// No backpressure: start is sampled only in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   Clk, Clear (async active-low)         clock and reset
//   start, op[3:0]                        request and ALU op code (12..15 illegal)
//   Rout_a, Yin, Rout_b, Zin              operand/Y/Z load strobes
//   Zlowout, Zhighout, LOin, HIin, Rzin   write-back strobes
//   alu_control[3:0]                      latched op while busy, 0 in IDLE
//   busy, done, illegal, op_count[15:0]   status and completed-legal-op counter
module alu_op_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Clear,
    input  logic        start,
    input  logic [3:0]  op,
    output logic        Rout_a,
    output logic        Yin,
    output logic        Rout_b,
    output logic [3:0]  alu_control,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic        Rzin,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Y,
        S_EXEC,
        S_CAPT,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_t;

    // Last value of the hold counter before leaving EXEC.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  op_q;
    logic [3:0]  hold_cnt;
    logic [15:0] op_count_r;

    // div/mul produce a 64-bit result written back through LO and HI.
    logic op_wide;
    logic op_bad;
    logic req_bad;

    assign op_wide = (op_q[3:1] == 3'b000);
    assign op_bad  = (op_q[3:2] == 2'b11);
    assign req_bad = (op[3:2] == 2'b11);

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state      <= S_IDLE;
            op_q       <= 4'd0;
            hold_cnt   <= 4'd0;
            op_count_r <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                op_q <= op;
            end
            // Counter runs only inside EXEC so every entry starts from zero.
            if (state == S_EXEC) begin
                hold_cnt <= hold_cnt + 4'd1;
            end else begin
                hold_cnt <= 4'd0;
            end
            if (state == S_DONE && !op_bad) begin
                op_count_r <= op_count_r + 16'd1;
            end
        end
    end

    assign op_count = op_count_r;

    // Next state plus Moore-decoded strobes; outputs depend on registered state only.
    always_comb begin
        state_nxt   = state;
        Rout_a      = 1'b0;
        Yin         = 1'b0;
        Rout_b      = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        LOin        = 1'b0;
        HIin        = 1'b0;
        Rzin        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        busy        = (state != S_IDLE);
        alu_control = (state != S_IDLE) ? op_q : 4'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = req_bad ? S_DONE : S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                Rout_a    = 1'b1;
                Yin       = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                Rout_b = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                Rout_b    = 1'b1;
                Zin       = 1'b1;
                state_nxt = S_WB_LO;
            end
            S_WB_LO: begin
                Zlowout = 1'b1;
                if (op_wide) begin
                    LOin      = 1'b1;
                    state_nxt = S_WB_HI;
                end else begin
                    Rzin      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WB_HI: begin
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                illegal   = op_bad;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (HOLD_CYCLES=1 and 3) checked cycle by cycle
// against per-cycle expected output records queued when each request is driven.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [8:0]  strb;   // {Rout_a,Yin,Rout_b,Zin,Zlowout,Zhighout,LOin,HIin,Rzin}
        logic [3:0]  ac;
        logic        busy;
        logic        done;
        logic        ill;
        logic [15:0] opc;
    } obs_t;

    logic       Clk;
    logic       Clear;
    logic       st0, st1;
    logic [3:0] op0, op1;

    wire [8:0]  s0, s1;
    wire [3:0]  ac0, ac1;
    wire        busy0, busy1, done0, done1, ill0, ill1;
    wire [15:0] opc0, opc1;

    obs_t obs0, obs1;
    assign obs0 = {s0, ac0, busy0, done0, ill0, opc0};
    assign obs1 = {s1, ac1, busy1, done1, ill1, opc1};

    obs_t        q0[$];
    obs_t        q1[$];
    logic [15:0] mc0, mc1;
    int          tests;
    int          fails;

    alu_op_sequencer #(.HOLD_CYCLES(1)) dut0 (
        .Clk(Clk), .Clear(Clear), .start(st0), .op(op0),
        .Rout_a(s0[8]), .Yin(s0[7]), .Rout_b(s0[6]), .alu_control(ac0),
        .Zin(s0[5]), .Zlowout(s0[4]), .Zhighout(s0[3]), .LOin(s0[2]),
        .HIin(s0[1]), .Rzin(s0[0]), .busy(busy0), .done(done0),
        .illegal(ill0), .op_count(opc0)
    );

    alu_op_sequencer #(.HOLD_CYCLES(3)) dut1 (
        .Clk(Clk), .Clear(Clear), .start(st1), .op(op1),
        .Rout_a(s1[8]), .Yin(s1[7]), .Rout_b(s1[6]), .alu_control(ac1),
        .Zin(s1[5]), .Zlowout(s1[4]), .Zhighout(s1[3]), .LOin(s1[2]),
        .HIin(s1[1]), .Rzin(s1[0]), .busy(busy1), .done(done1),
        .illegal(ill1), .op_count(opc1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single bus driver: Rout_a, Rout_b, Zlowout, Zhighout are mutually exclusive.
    always @(negedge Clk) begin
        tests++;
        assert ($onehot0({s0[8], s0[6], s0[4], s0[3]})) else begin
            fails++;
            $error("FAIL bus_excl_d0 got=%b required=onehot0", {s0[8], s0[6], s0[4], s0[3]});
        end
        tests++;
        assert ($onehot0({s1[8], s1[6], s1[4], s1[3]})) else begin
            fails++;
            $error("FAIL bus_excl_d1 got=%b required=onehot0", {s1[8], s1[6], s1[4], s1[3]});
        end
    end

    function automatic obs_t mk(logic [8:0] s, logic [3:0] a, logic b, logic d, logic i,
                                logic [15:0] c);
        obs_t r;
        r.strb = s;
        r.ac   = a;
        r.busy = b;
        r.done = d;
        r.ill  = i;
        r.opc  = c;
        return r;
    endfunction

    task automatic put(input int d, input obs_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    // Queue the expected output of every cycle from acceptance through the following IDLE cycle.
    task automatic push_op(input int d, input logic [3:0] o, input int h);
        logic [15:0] c;
        c = (d == 0) ? mc0 : mc1;
        if (o >= 4'd12) begin
            put(d, mk(9'h000, o, 1'b1, 1'b1, 1'b1, c));
        end else begin
            put(d, mk(9'h180, o, 1'b1, 1'b0, 1'b0, c));
            for (int i = 0; i < h; i++) put(d, mk(9'h040, o, 1'b1, 1'b0, 1'b0, c));
            put(d, mk(9'h060, o, 1'b1, 1'b0, 1'b0, c));
            if (o <= 4'd1) begin
                put(d, mk(9'h014, o, 1'b1, 1'b0, 1'b0, c));
                put(d, mk(9'h00A, o, 1'b1, 1'b0, 1'b0, c));
            end else begin
                put(d, mk(9'h011, o, 1'b1, 1'b0, 1'b0, c));
            end
            put(d, mk(9'h000, o, 1'b1, 1'b1, 1'b0, c));
            c = c + 16'd1;
        end
        put(d, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, c));
        if (d == 0) mc0 = c;
        else        mc1 = c;
    endtask

    task automatic chk_now(input int d, input obs_t exp, input string tag);
        obs_t got;
        got = (d == 0) ? obs0 : obs1;
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s_d%0d got=%h required=%h", tag, d, got, exp);
        end
    endtask

    // With nothing queued the instance must sit idle with the modelled count.
    task automatic check_cycle(input int d);
        obs_t exp;
        if (d == 0) exp = (q0.size() > 0) ? q0.pop_front() : mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, mc0);
        else        exp = (q1.size() > 0) ? q1.pop_front() : mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, mc1);
        chk_now(d, exp, "cycle");
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        check_cycle(0);
        check_cycle(1);
    endtask

    task automatic drain();
        while (q0.size() > 0 || q1.size() > 0) tick();
        tick();
    endtask

    task automatic issue(input int d, input logic [3:0] o);
        if (d == 0) begin st0 = 1'b1; op0 = o; end
        else        begin st1 = 1'b1; op1 = o; end
        push_op(d, o, (d == 0) ? 1 : 3);
        tick();
        if (d == 0) st0 = 1'b0;
        else        st1 = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mc0   = 16'd0;
        mc1   = 16'd0;
        Clear = 1'b0;
        st0   = 1'b0;
        st1   = 1'b0;
        op0   = 4'd0;
        op1   = 4'd0;

        // Reset state
        #3;
        chk_now(0, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0), "reset");
        chk_now(1, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0), "reset");
        @(negedge Clk);
        Clear = 1'b1;
        tick();
        tick();

        // add, HOLD_CYCLES=1: done in cycle 5, op_count -> 1
        issue(0, 4'd2);
        drain();

        // mul, HOLD_CYCLES=3: LO/HI write-back, done in cycle 8
        issue(1, 4'd1);
        drain();

        // illegal op: done+illegal in cycle 1, count unchanged
        issue(0, 4'd13);
        drain();

        // start pulses while busy are ignored
        issue(1, 4'd5);
        st1 = 1'b1;
        op1 = 4'd7;
        tick();
        tick();
        st1 = 1'b0;
        drain();

        // start held high: back-to-back ops with one IDLE cycle between
        st0 = 1'b1;
        op0 = 4'd3;
        push_op(0, 4'd3, 1);
        push_op(0, 4'd3, 1);
        repeat (8) tick();
        st0 = 1'b0;
        drain();

        // Clear during EXEC of div: immediate idle outputs, no done, count cleared
        issue(1, 4'd0);
        tick();
        Clear = 1'b0;
        #1;
        chk_now(0, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0), "clear_async");
        chk_now(1, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0), "clear_async");
        q0.delete();
        q1.delete();
        mc0 = 16'd0;
        mc1 = 16'd0;
        tick();
        Clear = 1'b1;
        tick();
        issue(1, 4'd10);
        drain();

        // op_count wrap 0xFFFF -> 0x0000
        force dut0.op_count_r = 16'hFFFF;
        #1;
        release dut0.op_count_r;
        mc0 = 16'hFFFF;
        tick();
        issue(0, 4'd4);
        drain();

        // Remaining op codes on both instances
        issue(0, 4'd0);
        drain();
        issue(0, 4'd9);
        drain();
        issue(0, 4'd11);
        drain();
        issue(0, 4'd12);
        drain();
        issue(1, 4'd7);
        drain();
        issue(1, 4'd15);
        drain();
        issue(1, 4'd6);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: number of EXEC cycles that operands and alu_control are held before Z capture; legal range 1..15.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Clear  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  4  ALU operation code: 0 div, 1 mul, 2 add, 3 sub, 4 shl, 5 shr, 6 ror, 7 rol, 8 or, 9 neg, 10 and, 11 not; 12..15 illegal.
REQ-006 Rout_a  output  1  drive operand A onto the bus.
REQ-007 Yin  output  1  load the Y register (ALU reg1 source) from the bus.
REQ-008 Rout_b  output  1  drive operand B onto the bus (ALU reg2 source).
REQ-009 alu_control  output  4  ALU control code.
REQ-010 Zin  output  1  capture the 64-bit ALU result into Z.
REQ-011 Zlowout  output  1  drive Z[31:0] onto the bus.
REQ-012 Zhighout  output  1  drive Z[63:32] onto the bus.
REQ-013 LOin / HIin  output  1 each  load the LO / HI register from the bus.
REQ-014 Rzin  output  1  load the destination register from the bus.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  single-cycle completion pulse.
REQ-017 illegal  output  1  qualifies done; high when the completed request had op >= 12.
REQ-018 op_count  output  16  count of completed legal operations.

Function
REQ-019 States: IDLE, LOAD_Y, EXEC, CAPT, WB_LO, WB_HI, DONE.
REQ-020 IDLE: start=1 at an edge latches op and moves to LOAD_Y if op <= 11, or straight to DONE with illegal flagged if op >= 12; start=0 stays in IDLE.
REQ-021 start while busy is ignored; the request is not queued.
REQ-022 LOAD_Y (1 cycle): Rout_a=1, Yin=1.
REQ-023 EXEC (HOLD_CYCLES cycles, counted by an internal 4-bit counter): Rout_b=1.
REQ-024 CAPT (1 cycle): Rout_b=1, Zin=1.
REQ-025 WB_LO (1 cycle): Zlowout=1. For ops 0/1, LOin=1 then go to WB_HI; otherwise Rzin=1 then go to DONE.
REQ-026 WB_HI (1 cycle, ops 0/1 only): Zhighout=1, HIin=1.
REQ-027 DONE (1 cycle): done=1; illegal=1 if the latched op >= 12. Then return to IDLE, so a new start is accepted at the next edge at the earliest.
REQ-028 alu_control equals the latched op in every non-IDLE state, and 0 in IDLE.
REQ-029 All strobes not listed for a state are 0. Strobes are registered (decoded from the registered state), so no combinational path runs from start/op to any output.
REQ-030 Latency, counted from the accepting edge to the cycle in which done is high:
  - ops 2..11: 4+HOLD_CYCLES cycles.
  - ops 0/1: 5+HOLD_CYCLES cycles.
  - illegal ops: 1 cycle.
REQ-031 op_count increments by 1 on leaving DONE for a legal op and wraps 0xFFFF -> 0x0000. It is unchanged for illegal ops.
REQ-032 At most one of Rout_a, Rout_b, Zlowout, Zhighout is high in any cycle (single bus driver).

Reset
REQ-033 Clear=0 forces state IDLE, all strobes 0, alu_control=0, busy=0, done=0, illegal=0, op_count=0, and clears the hold counter and latched op immediately, independent of Clk.
REQ-034 Clear asserted mid-operation aborts the operation with no done pulse. After release, the first rising edge with start=1 is accepted normally.

Verification
REQ-035 HOLD_CYCLES=1, op=2, start pulsed 1 cycle -> LOAD_Y, EXEC, CAPT, WB_LO(Rzin), DONE in consecutive cycles; done in cycle 5; alu_control=2 throughout; op_count=1.
REQ-036 HOLD_CYCLES=3, op=1 -> EXEC lasts 3 cycles; WB_LO asserts LOin (Rzin=0), WB_HI asserts Zhighout+HIin; done in cycle 8.
REQ-037 op=13 -> done and illegal high in cycle 1 after acceptance; no strobes; op_count unchanged.
REQ-038 start held high continuously with op=3 -> back-to-back operations with exactly one IDLE cycle between a DONE and the next LOAD_Y; start pulses during busy have no effect.
REQ-039 Clear pulsed low during EXEC of op=0 -> all outputs 0 within the same cycle; no done; next start with op=10 completes with op_count=1.
REQ-040 Preload scenario: run 65536 legal ops (or force op_count=0xFFFF), then one more op -> op_count=0x0000; bus-driver exclusivity (REQ-032) is asserted every cycle.
